// File: rtl/masked_sbox_lanes.sv
// Multi-lane handshaked front end for a pipelined DOM-masked AES S-box.
// Valid tags track tokens through the cores; randomness starvation squashes them.
package masked_sbox_pkg;
    function automatic int unsigned _blind_nrnd(input int unsigned shares);
        return shares * (shares - 1);
    endfunction
endpackage

// Four-register DOM-masked GF(2^8) inverter (x^254) plus the linear part of the
// AES affine map; the 0x63 constant is left to the wrapper.
module masked_sbox_core #(
    parameter int unsigned SHARES = 2,
    parameter int unsigned RND_W  = 38
) (
    input  logic                  ClkxCI,
    input  logic                  RstxBI,
    input  logic [8*SHARES-1:0]   XxDI,
    input  logic [RND_W-1:0]      RndxDI,
    output logic [8*SHARES-1:0]   QxDO
);
    localparam int unsigned NP     = SHARES * (SHARES - 1) / 2;
    localparam int unsigned USED_W = 32 * NP;

    typedef logic [SHARES-1:0][7:0]              shares_t;
    typedef logic [SHARES-1:0][SHARES-1:0][7:0]  prods_t;
    typedef logic [NP-1:0][7:0]                  zbytes_t;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = '0;
        sh  = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) acc ^= sh;
            sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1B : 8'h00);
        end
        return acc;
    endfunction

    // Squaring is linear, so it is applied share-wise without randomness.
    function automatic shares_t pow2n(input shares_t a, input int unsigned n);
        shares_t r;
        r = a;
        for (int unsigned s = 0; s < SHARES; s++)
            for (int unsigned k = 0; k < n; k++)
                r[s] = gf_mul(r[s], r[s]);
        return r;
    endfunction

    function automatic prods_t dom_mul(input shares_t a, input shares_t b, input zbytes_t z);
        prods_t      p;
        int unsigned k;
        k = 0;
        for (int unsigned i = 0; i < SHARES; i++)
            for (int unsigned j = 0; j < SHARES; j++)
                p[i][j] = gf_mul(a[i], b[j]);
        for (int unsigned i = 0; i < SHARES; i++)
            for (int unsigned j = i + 1; j < SHARES; j++) begin
                p[i][j] ^= z[k];
                p[j][i] ^= z[k];
                k++;
            end
        return p;
    endfunction

    function automatic shares_t compress(input prods_t p);
        shares_t c;
        c = '0;
        for (int unsigned i = 0; i < SHARES; i++)
            for (int unsigned j = 0; j < SHARES; j++)
                c[i] ^= p[i][j];
        return c;
    endfunction

    function automatic logic [7:0] affine_lin(input logic [7:0] a);
        logic [7:0] b;
        b = '0;
        for (int unsigned i = 0; i < 8; i++)
            b[i] = a[i] ^ a[3'(i + 4)] ^ a[3'(i + 5)] ^ a[3'(i + 6)] ^ a[3'(i + 7)];
        return b;
    endfunction

    logic [3:0][NP-1:0][7:0] zb;
    prods_t  p1, p2, p3, p4;
    shares_t x_in, x2_s1, x2_s2, x2_s3, x12_s2;
    shares_t x3, x12, x15, x240, x252, y;

    // Spare random bits are folded into the first mask byte so none go unused.
    always_comb begin
        zb = '0;
        for (int unsigned m = 0; m < 4; m++)
            for (int unsigned p = 0; p < NP; p++)
                zb[m][p] = RndxDI[(m*NP+p)*8 +: 8];
        for (int unsigned i = USED_W; i < RND_W; i++)
            zb[0][0][3'(i)] = zb[0][0][3'(i)] ^ RndxDI[i];
    end

    assign x_in = XxDI;
    assign x3   = compress(p1);
    assign x12  = pow2n(x3, 2);
    assign x15  = compress(p2);
    assign x240 = pow2n(x15, 4);
    assign x252 = compress(p3);

    always_comb begin
        y = compress(p4);
        for (int unsigned s = 0; s < SHARES; s++)
            y[s] = affine_lin(y[s]);
    end
    assign QxDO = y;

    // x^3 -> x^15 -> x^252 -> x^254, one DOM multiply per register stage.
    always_ff @(posedge ClkxCI) begin
        if (!RstxBI) begin
            p1     <= '0;
            p2     <= '0;
            p3     <= '0;
            p4     <= '0;
            x2_s1  <= '0;
            x2_s2  <= '0;
            x2_s3  <= '0;
            x12_s2 <= '0;
        end else begin
            p1     <= dom_mul(pow2n(x_in, 1), x_in, zb[0]);
            x2_s1  <= pow2n(x_in, 1);
            p2     <= dom_mul(x12, x3, zb[1]);
            x12_s2 <= x12;
            x2_s2  <= x2_s1;
            p3     <= dom_mul(x240, x12_s2, zb[2]);
            x2_s3  <= x2_s2;
            p4     <= dom_mul(x252, x2_s3, zb[3]);
        end
    end
endmodule

module masked_sbox_lanes
    import masked_sbox_pkg::*;
#(
    parameter int unsigned SHARES    = 2,
    parameter int unsigned LANES     = 4,
    parameter int unsigned CORE_LAT  = 4,
    parameter int unsigned ADD_CONST = 1
) (
    input  logic                                    ClkxCI,
    input  logic                                    RstxSI,
    input  logic                                    InValidxSI,
    output logic                                    InReadyxSO,
    input  logic [8*SHARES*LANES-1:0]               XxDI,
    input  logic                                    RndValidxSI,
    input  logic [11*SHARES*(SHARES-1)*LANES-1:0]   RandomZxDI,
    input  logic [8*_blind_nrnd(SHARES)*LANES-1:0]  RandomBxDI,
    output logic                                    OutValidxSO,
    output logic [8*SHARES*LANES-1:0]               QxDO,
    output logic                                    BusyxSO,
    output logic                                    RndErrxSO,
    output logic [15:0]                             CntxDO
);
    localparam int unsigned BYTE_W = 8 * SHARES;
    localparam int unsigned DW     = BYTE_W * LANES;
    localparam int unsigned ZW     = 11 * SHARES * (SHARES - 1);
    localparam int unsigned BW     = 8 * _blind_nrnd(SHARES);

    logic [CORE_LAT-1:0] TagxDP, TagxDN;
    logic [DW-1:0]       core_q, const_mask;
    logic                transfer, squash;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        masked_sbox_core #(
            .SHARES (SHARES),
            .RND_W  (ZW + BW)
        ) u_core (
            .ClkxCI (ClkxCI),
            .RstxBI (~RstxSI),
            .XxDI   (XxDI[l*BYTE_W +: BYTE_W]),
            .RndxDI ({RandomBxDI[l*BW +: BW], RandomZxDI[l*ZW +: ZW]}),
            .QxDO   (core_q[l*BYTE_W +: BYTE_W])
        );
    end

    assign InReadyxSO = RndValidxSI & ~RndErrxSO;
    assign transfer   = InValidxSI & InReadyxSO;
    assign squash     = ~RndValidxSI & (|TagxDP);
    assign BusyxSO    = (|TagxDP) | OutValidxSO;

    always_comb begin
        TagxDN = '0;
        if (!squash) begin
            TagxDN[0] = transfer;
            for (int unsigned k = 1; k < CORE_LAT; k++)
                TagxDN[k] = TagxDP[k-1];
        end
    end

    always_comb begin
        const_mask = '0;
        if (ADD_CONST != 0)
            for (int unsigned l = 0; l < LANES; l++)
                const_mask[l*BYTE_W +: 8] = 8'h63;
    end

    always_ff @(posedge ClkxCI) begin
        if (RstxSI) begin
            TagxDP      <= '0;
            QxDO        <= '0;
            OutValidxSO <= 1'b0;
            RndErrxSO   <= 1'b0;
            CntxDO      <= '0;
        end else begin
            TagxDP <= TagxDN;
            if (squash) RndErrxSO <= 1'b1;
            // Shares are zeroed whenever the output is not valid.
            if (TagxDP[CORE_LAT-1] && !squash) begin
                QxDO        <= core_q ^ const_mask;
                OutValidxSO <= 1'b1;
            end else begin
                QxDO        <= '0;
                OutValidxSO <= 1'b0;
            end
            if (OutValidxSO) CntxDO <= CntxDO + 16'd1;
        end
    end
endmodule

// File: tb/tb_masked_sbox_lanes.sv
// Directed bench for masked_sbox_lanes: latency, streaming, squash, reset, counter wrap.
module tb_masked_sbox_lanes;
    localparam int XW = 64;
    localparam int ZW = 88;
    localparam int BW = 8 * masked_sbox_pkg::_blind_nrnd(2) * 4;

    localparam logic [7:0] SBOX [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    logic          clk = 1'b0;
    logic          rst, in_valid, rnd_valid;
    logic [XW-1:0] x;
    logic [ZW-1:0] rz;
    logic [BW-1:0] rb;
    logic          in_ready, out_valid, busy, rnd_err;
    logic [XW-1:0] q;
    logic [15:0]   cnt;
    logic          in_ready_nc, out_valid_nc, busy_nc, rnd_err_nc;
    logic [XW-1:0] q_nc;
    logic [15:0]   cnt_nc;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    masked_sbox_lanes #(.SHARES(2), .LANES(4), .CORE_LAT(4), .ADD_CONST(1)) dut (
        .ClkxCI(clk), .RstxSI(rst), .InValidxSI(in_valid), .InReadyxSO(in_ready),
        .XxDI(x), .RndValidxSI(rnd_valid), .RandomZxDI(rz), .RandomBxDI(rb),
        .OutValidxSO(out_valid), .QxDO(q), .BusyxSO(busy), .RndErrxSO(rnd_err), .CntxDO(cnt)
    );

    masked_sbox_lanes #(.SHARES(2), .LANES(4), .CORE_LAT(4), .ADD_CONST(0)) dut_nc (
        .ClkxCI(clk), .RstxSI(rst), .InValidxSI(in_valid), .InReadyxSO(in_ready_nc),
        .XxDI(x), .RndValidxSI(rnd_valid), .RandomZxDI(rz), .RandomBxDI(rb),
        .OutValidxSO(out_valid_nc), .QxDO(q_nc), .BusyxSO(busy_nc), .RndErrxSO(rnd_err_nc), .CntxDO(cnt_nc)
    );

    function automatic logic [7:0] lane_of(input logic [XW-1:0] v, input int l);
        return v[l*16 +: 8] ^ v[l*16+8 +: 8];
    endfunction

    task automatic next_edge();
        logic [95:0] t;
        @(posedge clk);
        #1;
        t  = {$urandom(), $urandom(), $urandom()};
        rz = t[ZW-1:0];
        rb = {$urandom(), $urandom()};
    endtask

    task automatic drive_vec(input logic [3:0][7:0] b);
        logic [7:0] m;
        for (int l = 0; l < 4; l++) begin
            m = 8'($urandom());
            x[l*16 +: 8]   = b[l] ^ m;
            x[l*16+8 +: 8] = m;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; rnd_valid = 1'b0; x = '0;
        next_edge();
        next_edge();
        rst = 1'b0;
        @(negedge clk);
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        vectors++; if (q !== '0) begin miscompares++; $display("FAIL reset_q: got %h want 0", q); end
        vectors++; if (cnt !== 16'h0) begin miscompares++; $display("FAIL reset_cnt: got %h want 0", cnt); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (rnd_err !== 1'b0) begin miscompares++; $display("FAIL reset_rnd_err: got %b want 0", rnd_err); end
        repeat (3) next_edge();
        @(negedge clk);
        vectors++; if (rnd_err !== 1'b0) begin miscompares++; $display("FAIL idle_starve_err: got %b want 0", rnd_err); end
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL idle_starve_ready: got %b want 0", in_ready); end
        rnd_valid = 1'b1;
        #1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL ready_follows_rnd: got %b want 1", in_ready); end
    endtask

    task automatic test_latency();
        logic [3:0][7:0] b;
        next_edge();
        b = {8'hFF, 8'h53, 8'h01, 8'h00};
        drive_vec(b);
        in_valid = 1'b1;
        next_edge();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL latency_early_%0d: got %b want 0", k, out_valid); end
            vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL latency_busy_%0d: got %b want 1", k, busy); end
            next_edge();
        end
        @(negedge clk);
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL latency_valid: got %b want 1", out_valid); end
        vectors++; if (lane_of(q, 0) !== 8'h63) begin miscompares++; $display("FAIL lat_lane0: got %h want 63", lane_of(q, 0)); end
        vectors++; if (lane_of(q, 1) !== 8'h7C) begin miscompares++; $display("FAIL lat_lane1: got %h want 7c", lane_of(q, 1)); end
        vectors++; if (lane_of(q, 2) !== 8'hED) begin miscompares++; $display("FAIL lat_lane2: got %h want ed", lane_of(q, 2)); end
        vectors++; if (lane_of(q, 3) !== 8'h16) begin miscompares++; $display("FAIL lat_lane3: got %h want 16", lane_of(q, 3)); end
        vectors++; if (lane_of(q_nc, 0) !== 8'h00) begin miscompares++; $display("FAIL noconst_lane0: got %h want 00", lane_of(q_nc, 0)); end
        vectors++; if (lane_of(q_nc, 2) !== 8'h8E) begin miscompares++; $display("FAIL noconst_lane2: got %h want 8e", lane_of(q_nc, 2)); end
        next_edge();
        @(negedge clk);
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL latency_drop: got %b want 0", out_valid); end
        vectors++; if (q !== '0) begin miscompares++; $display("FAIL latency_q_clear: got %h want 0", q); end
        vectors++; if (cnt !== 16'd1) begin miscompares++; $display("FAIL latency_cnt: got %0d want 1", cnt); end
    endtask

    task automatic test_stream();
        logic [3:0][7:0] b;
        int v;
        rst = 1'b1;
        next_edge();
        rst = 1'b0;
        for (int c = 0; c < 262; c++) begin
            if (c < 256) begin
                for (int l = 0; l < 4; l++) b[l] = 8'(c + 64*l);
                drive_vec(b);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (c >= 5 && c < 261) begin
                v = c - 5;
                vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL stream_valid_%0d: got %b want 1", v, out_valid); end
                for (int l = 0; l < 4; l++) begin
                    vectors++;
                    if (lane_of(q, l) !== SBOX[(v + 64*l) & 255]) begin
                        miscompares++;
                        $display("FAIL stream_v%0d_lane%0d: got %h want %h", v, l, lane_of(q, l), SBOX[(v + 64*l) & 255]);
                    end
                end
                vectors++;
                if (lane_of(q_nc, 0) !== (SBOX[v] ^ 8'h63)) begin
                    miscompares++;
                    $display("FAIL stream_noconst_v%0d: got %h want %h", v, lane_of(q_nc, 0), SBOX[v] ^ 8'h63);
                end
            end else begin
                vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL stream_idle_%0d: got %b want 0", c, out_valid); end
            end
            next_edge();
        end
        @(negedge clk);
        vectors++; if (cnt !== 16'd256) begin miscompares++; $display("FAIL stream_cnt: got %0d want 256", cnt); end
    endtask

    task automatic test_reset_midstream();
        logic [3:0][7:0] b;
        b = {8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 3; i++) begin
            drive_vec(b);
            in_valid = 1'b1;
            next_edge();
        end
        rst = 1'b1;
        in_valid = 1'b0;
        next_edge();
        rst = 1'b0;
        @(negedge clk);
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
        vectors++; if (q !== '0) begin miscompares++; $display("FAIL midrst_q: got %h want 0", q); end
        vectors++; if (cnt !== 16'd0) begin miscompares++; $display("FAIL midrst_cnt: got %0d want 0", cnt); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy: got %b want 0", busy); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_ready: got %b want 1", in_ready); end
        for (int k = 0; k < 8; k++) begin
            next_edge();
            @(negedge clk);
            vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_stale_%0d: got %b want 0", k, out_valid); end
        end
        vectors++; if (cnt !== 16'd0) begin miscompares++; $display("FAIL midrst_cnt_after: got %0d want 0", cnt); end
    endtask

    task automatic test_squash();
        logic [3:0][7:0] b;
        b = {8'hA5, 8'h5A, 8'hC3, 8'h3C};
        rst = 1'b1;
        next_edge();
        rst = 1'b0;
        drive_vec(b);
        in_valid = 1'b1;
        next_edge();
        in_valid = 1'b0;
        next_edge();
        rnd_valid = 1'b0;
        @(negedge clk);
        vectors++; if (rnd_err !== 1'b0) begin miscompares++; $display("FAIL squash_err_early: got %b want 0", rnd_err); end
        next_edge();
        rnd_valid = 1'b1;
        in_valid = 1'b1;
        drive_vec(b);
        @(negedge clk);
        vectors++; if (rnd_err !== 1'b1) begin miscompares++; $display("FAIL squash_err: got %b want 1", rnd_err); end
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL squash_ready: got %b want 0", in_ready); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL squash_busy: got %b want 0", busy); end
        for (int k = 0; k < 8; k++) begin
            next_edge();
            @(negedge clk);
            vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL squash_valid_%0d: got %b want 0", k, out_valid); end
            vectors++; if (q !== '0) begin miscompares++; $display("FAIL squash_q_%0d: got %h want 0", k, q); end
            vectors++; if (rnd_err !== 1'b1) begin miscompares++; $display("FAIL squash_sticky_%0d: got %b want 1", k, rnd_err); end
            vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL squash_ready_%0d: got %b want 0", k, in_ready); end
        end
        vectors++; if (cnt !== 16'd0) begin miscompares++; $display("FAIL squash_cnt: got %0d want 0", cnt); end
        in_valid = 1'b0;
    endtask

    task automatic test_cnt_wrap();
        logic [3:0][7:0] b;
        b = {8'h00, 8'h01, 8'h53, 8'hFF};
        rst = 1'b1;
        next_edge();
        rst = 1'b0;
        drive_vec(b);
        in_valid = 1'b1;
        for (int i = 0; i < 65535; i++) next_edge();
        in_valid = 1'b0;
        repeat (6) next_edge();
        @(negedge clk);
        vectors++; if (cnt !== 16'hFFFF) begin miscompares++; $display("FAIL wrap_full: got %h want ffff", cnt); end
        drive_vec(b);
        in_valid = 1'b1;
        next_edge();
        in_valid = 1'b0;
        repeat (4) next_edge();
        @(negedge clk);
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL wrap_last_valid: got %b want 1", out_valid); end
        vectors++; if (lane_of(q, 1) !== 8'hED) begin miscompares++; $display("FAIL wrap_last_data: got %h want ed", lane_of(q, 1)); end
        next_edge();
        @(negedge clk);
        vectors++; if (cnt !== 16'h0000) begin miscompares++; $display("FAIL wrap_zero: got %h want 0000", cnt); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rz = '0;
        rb = '0;
        test_reset();
        test_latency();
        test_stream();
        test_reset_midstream();
        test_squash();
        test_cnt_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/masked_sbox_lanes.md
# masked_sbox_lanes

Multi-lane, handshaked front end for the team's pipelined DOM-masked AES S-box core. It instantiates `LANES` copies of the core (PIPELINED=1, EIGHT_STAGED=0) and routes per-lane fresh randomness to each. It adds the affine constant 0x63 on share 0, tracks in-flight transactions with a valid-tag pipeline, and squashes all in-flight data if randomness supply fails. It sits between the round datapath (SubBytes on a column or a full state) and the PRNG.

## Interface
Parameters:
- `SHARES`, 2: number of Boolean shares per byte (≥2).
- `LANES`, 4: parallel S-box lanes (1..16).
- `CORE_LAT`, 4: register depth of the S-box core, input to output. It must equal the depth of the instantiated core.
- `ADD_CONST`, 1: when 1, XOR 0x63 into share 0 of every output byte; when 0, pass the core output unchanged.

Ports:
- `ClkxCI` in 1: the only clock.
- `RstxSI` in 1: reset, synchronous, active-high. The core reset inputs are driven by `~RstxSI`.
- `InValidxSI` in 1: input byte vector valid.
- `InReadyxSO` out 1: block accepts the input this cycle.
- `XxDI` in 8·SHARES·LANES: input shares. The lane l, share s byte is at `[(l·SHARES+s)·8 +: 8]`.
- `RndValidxSI` in 1: PRNG output valid this cycle.
- `RandomZxDI` in 11·SHARES·(SHARES−1)·LANES: DOM randomness, lane-sliced contiguously.
- `RandomBxDI` in 8·_blind_nrnd(SHARES)·LANES: blinding randomness, lane-sliced contiguously.
- `OutValidxSO` out 1: output valid. There is no output backpressure.
- `QxDO` out 8·SHARES·LANES: output shares, same layout as `XxDI`.
- `BusyxSO` out 1: at least one token is in flight.
- `RndErrxSO` out 1: sticky flag for randomness starvation.
- `CntxDO` out 16: count of completed transactions.

## Operation
- Acceptance:
  - `InReadyxSO` = `RndValidxSI & ~RndErrxSO`.
  - A transfer occurs when `InValidxSI & InReadyxSO`.
- Each core receives its lane's `XxDI` slice every cycle. Pipeline data advances freely every cycle.
- Valid-tag shift register `TagxDP[CORE_LAT-1:0]`:
  - Bit 0 loads the transfer flag.
  - Bit k loads bit k−1.
  - Bit CORE_LAT−1 feeds the output stage.
- Randomness is forwarded combinationally to the cores every cycle. The PRNG must hold `RndValidxSI` high while any tag bit is set or a transfer occurs.
- Starvation: if `RndValidxSI`=0 in a cycle where any `TagxDP` bit is 1:
  - Clear all `TagxDP` bits on the next edge.
  - Set `RndErrxSO`. It remains set until reset.
  - No output of the squashed tokens is ever flagged valid.
- Output register, updated every cycle:
  - If the last tag is set and no squash occurs that cycle: `QxDO` ← core outputs, with share 0 of each lane XOR 0x63 when `ADD_CONST`=1. `OutValidxSO` ← 1.
  - Otherwise: `QxDO` ← 0 and `OutValidxSO` ← 0. Shares are never left on the bus when invalid.
- `CntxDO` increments by 1 on each cycle in which `OutValidxSO` is asserted, wrapping 0xFFFF→0x0000.
- `BusyxSO` = OR of `TagxDP` bits OR `OutValidxSO`.
- Simultaneous transfer and squash cannot occur, because a transfer requires `RndValidxSI`=1.
- Reset takes priority over all other events. On the reset cycle:
  - `TagxDP`, `QxDO`, `OutValidxSO`, `RndErrxSO` and `CntxDO` all ← 0.
  - Cores are cleared.
  - Tokens in flight are dropped silently.

## Timing
- Reset values:
  - All outputs are 0.
  - `InReadyxSO` follows `RndValidxSI` combinationally after reset.
- Latency: a transfer at edge t appears with `OutValidxSO`=1 in the cycle after edge t+CORE_LAT, i.e. CORE_LAT+1 cycles.
- Throughput: one vector per cycle while `RndValidxSI`=1. Back-to-back transfers produce back-to-back outputs.
- Squash detected in cycle c: `TagxDP`=0 from edge c+1. `OutValidxSO` is 0 in cycle c+1 and stays 0 until reset. `InReadyxSO` drops in cycle c+1.
- Idle starvation is not an error: `RndValidxSI`=0 with all tags clear leaves `RndErrxSO`=0 and only deasserts `InReadyxSO`.

## Test plan
- SHARES=2, LANES=4. Lanes hold bytes {0x00, 0x01, 0x53, 0xFF}, masked with random share 1, random Z/B. Required: `OutValidxSO` after exactly CORE_LAT+1 cycles, and the XOR of shares per lane is {0x63, 0x7C, 0xED, 0x16}.
- Stream 256 consecutive vectors covering all byte values on every lane. Required: outputs are back-to-back and in order, all match the AES S-box table, and `CntxDO`=256.
- `ADD_CONST`=0, input 0x00. Required: unmasked output 0x00. Input 0x53 → 0x8E.
- Drop `RndValidxSI` for one cycle two cycles after a transfer. Required: that token never produces an output, `RndErrxSO`=1 and stays, `InReadyxSO`=0, `QxDO`=0.
- Assert `RstxSI` mid-stream with 3 tokens in flight. Required: next cycle all outputs are 0 and `CntxDO`=0, and no stale `OutValidxSO` appears afterwards.
- Load `CntxDO` to 0xFFFF via 65535 transfers, then send 1 more. Required: `CntxDO` wraps to 0x0000.
